// File: rtl/axi_lite_master_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge
//
// Turns single-word load/store requests from the soft-core data port into
// AXI-lite master transactions toward the peripheral slaves. Only one
// transaction is outstanding at a time. A watchdog aborts any wait state that
// lasts TIMEOUT cycles and answers the core with an error.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we/req_addr/req_wdata store flag, byte address, store data
//   resp_valid               one-cycle response strobe
//   resp_rdata/resp_err      load data (0 for stores/errors), error flag
//   axi_ar*/axi_r*           AXI-lite read address / read data channels
//   axi_aw*/axi_w*           AXI-lite write address / write data channels
//   b_valid/b_ready/b_response  AXI-lite write response channel
//
// Every output is a register, computed from the next state, so the AXI side
// sees clean glitch-free valid/ready levels and reset clears them at once.
// -----------------------------------------------------------------------------
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_response
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The counter starts at 0 on state entry, so the last allowed wait cycle
  // is the one where it reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      wdog_q, wdog_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;

  logic                  expired;
  logic                  aw_done;
  logic                  w_done;
  logic                  wait_state;

  assign expired    = (wdog_q == WDOG_LAST);
  // A channel counts as finished if its valid already dropped or it
  // handshakes on this edge.
  assign aw_done    = !awvalid_q || axi_awready;
  assign w_done     = !wvalid_q  || axi_wready;
  assign wait_state = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                      (state_q == WR_ADDR_DATA) || (state_q == WR_RESP);

  always_comb begin
    state_d      = state_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          resp_rdata_d = '0;
          if (req_addr[1:0] != 2'b00) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (!req_we) begin
            state_d   = RD_ADDR;
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
          end else begin
            state_d   = WR_ADDR_DATA;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end

      RD_ADDR: begin
        if (axi_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expired) begin
          state_d    = RESP;
          arvalid_d  = 1'b0;
          resp_err_d = 1'b1;
        end
      end

      RD_DATA: begin
        if (axi_rvalid) begin
          state_d      = RESP;
          rready_d     = 1'b0;
          resp_rdata_d = axi_rdata;
        end else if (expired) begin
          state_d    = RESP;
          rready_d   = 1'b0;
          resp_err_d = 1'b1;
        end
      end

      WR_ADDR_DATA: begin
        // Each valid falls after its own handshake and never comes back.
        if (awvalid_q && axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (expired) begin
          state_d    = RESP;
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b0;
          resp_err_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (b_valid) begin
          state_d    = RESP;
          bready_d   = 1'b0;
          resp_err_d = (b_response != 2'b00);
        end else if (expired) begin
          state_d    = RESP;
          bready_d   = 1'b0;
          resp_err_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == IDLE);

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (wait_state) begin
      wdog_d = wdog_q + CNT_W'(1);
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wvalid  = wvalid_q;
  assign b_ready     = bready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
module tb_axi_lite_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        b_valid, b_ready;
  logic [1:0]  b_response;

  axi_lite_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi_araddr (axi_araddr),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata  (axi_rdata),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .axi_awaddr (axi_awaddr),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_response (b_response)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected response: data, error flag, accept edge, and latency in edges
  // counted from the accept edge through the edge that sets resp_valid,
  // both inclusive, plus one (the edge on which the core samples it).
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        if (e.lat >= 0) check("resp_latency", cyc - e.acc + 2, e.lat);
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic push, input logic [31:0] erd, input logic eerr,
                      input int lat);
    int g = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("req_ready_wait", 0, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      e.rdata = erd;
      e.err   = eerr;
      e.acc   = cyc + 1;
      e.lat   = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_resp();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("resp_wait_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},
          {56'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, b_ready,
           resp_valid, resp_err, req_ready}, 64'd0);
    check({tag, "_rdata"}, resp_rdata, 0);
    check({tag, "_araddr"}, axi_araddr, 0);
    check({tag, "_awaddr"}, axi_awaddr, 0);
    check({tag, "_wdata"}, axi_wdata, 0);
  endtask

  initial begin
    int cnt;
    logic bad;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = 0;
    axi_awready = 0; axi_wready = 0; b_valid = 0; b_response = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Zero-wait load returning 0xA
    axi_arready = 1; axi_rvalid = 1; axi_rdata = 32'h0000_000A;
    send(0, 32'h10, 0, 1, 32'h0000_000A, 0, 4);
    @(negedge clk);
    check("ld_arvalid_first", axi_arvalid, 1);
    check("ld_araddr", axi_araddr, 32'h10);
    check("ld_ready_busy", req_ready, 0);
    @(negedge clk);
    check("ld_arvalid_one_cycle", axi_arvalid, 0);
    check("ld_rready", axi_rready, 1);
    wait_resp();
    check("ld_ready_back", req_ready, 1);
    axi_arready = 0; axi_rvalid = 0;

    // Store 0x5 to 0x4, awready three cycles after wready
    axi_wready = 1; axi_awready = 0; b_valid = 0;
    send(1, 32'h4, 32'h5, 1, 32'h0, 0, 7);
    @(negedge clk);
    check("st_both_valid", {62'd0, axi_awvalid, axi_wvalid}, 64'h3);
    check("st_awaddr", axi_awaddr, 32'h4);
    check("st_wdata", axi_wdata, 32'h5);
    bad = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (!axi_awvalid || axi_wvalid || axi_awaddr != 32'h4 || axi_wdata != 32'h5) bad = 1;
      if (k == 3) axi_awready = 1;
    end
    check("st_w_dropped_aw_held", bad, 0);
    @(negedge clk);
    check("st_aw_dropped", {62'd0, axi_awvalid, axi_wvalid}, 64'h0);
    check("st_bready", b_ready, 1);
    b_valid = 1; b_response = 2'b00;
    @(negedge clk);
    b_valid = 0; axi_awready = 0; axi_wready = 0;
    wait_resp();

    // Store answered with SLVERR
    axi_awready = 1; axi_wready = 1; b_valid = 1; b_response = 2'b10;
    send(1, 32'h8, 32'h77, 1, 32'h0, 1, 4);
    wait_resp();
    axi_awready = 0; axi_wready = 0; b_valid = 0; b_response = 0;

    // Load with wait states on both read channels
    send(0, 32'h40, 0, 1, 32'hCAFE_F00D, 0, 6);
    @(negedge clk);
    @(negedge clk);
    axi_arready = 1;
    @(negedge clk);
    axi_arready = 0;
    check("ws_rready", axi_rready, 1);
    @(negedge clk);
    axi_rvalid = 1; axi_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    axi_rvalid = 0; axi_rdata = 0;
    wait_resp();

    // Misaligned load: error one cycle after accept, no AXI activity
    send(0, 32'h2, 0, 1, 32'h0, 1, 2);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (axi_arvalid || axi_awvalid || axi_wvalid) bad = 1;
    end
    check("mis_no_axi", bad, 0);
    wait_resp();

    // Slave never answers AR: watchdog fires after 15 cycles
    send(0, 32'h8, 0, 1, 32'h0, 1, 17);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (axi_arvalid) cnt++;
    end
    check("to_arvalid_cycles", cnt, 15);
    check("to_ready_back", req_ready, 1);
    check("to_scoreboard_empty", sb.size(), 0);
    axi_rvalid = 1; axi_rdata = 32'hBAD0_BAD0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (axi_rready) bad = 1;
    end
    axi_rvalid = 0;
    check("stray_r_ignored", bad, 0);

    // Reset while waiting for the write response
    axi_awready = 1; axi_wready = 1; b_valid = 0;
    send(1, 32'h100, 32'hDEAD, 0, 0, 0, -1);
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wr_resp_bready", b_ready, 1);
    axi_awready = 0; axi_wready = 0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", req_ready, 1);

    // Normal load after the abort
    axi_arready = 1; axi_rvalid = 1; axi_rdata = 32'h1234_5678;
    send(0, 32'h20, 0, 1, 32'h1234_5678, 0, 4);
    wait_resp();
    axi_arready = 0; axi_rvalid = 0;
    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
